// File: rtl/exe_csr_unit.sv
// Machine-mode CSR file for the execute stage: single-cycle CSR read-modify-write,
// illegal-access detection, trap entry / MRET state updates, registered fetch redirect
// and a free-running 64-bit cycle counter.
module exe_csr_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned CSRCTL_WIDTH = 2,
  parameter logic [63:0] MCYCLE_RST   = 64'd0
) (
  input  logic                    I_clk,
  input  logic                    I_rst_n,
  input  logic                    I_csr_valid,
  input  logic [11:0]             I_csr_addr,
  input  logic [CSRCTL_WIDTH-1:0] I_csr_ctrl,
  input  logic [XLEN-1:0]         I_csr_src,
  input  logic                    I_csr_src_x0,
  input  logic                    I_trap_valid,
  input  logic [XLEN-1:0]         I_trap_cause,
  input  logic [XLEN-1:0]         I_trap_pc,
  input  logic                    I_mret,
  output logic [XLEN-1:0]         O_csr_rdata,
  output logic                    O_csr_illegal,
  output logic                    O_redirect_valid,
  output logic [XLEN-1:0]         O_redirect_pc,
  output logic                    O_mie
);

  localparam logic [11:0] AddrMstatus   = 12'h300;
  localparam logic [11:0] AddrMtvec     = 12'h305;
  localparam logic [11:0] AddrMscratch  = 12'h340;
  localparam logic [11:0] AddrMepc      = 12'h341;
  localparam logic [11:0] AddrMcause    = 12'h342;
  localparam logic [11:0] AddrMcycle    = 12'hB00;
  localparam logic [11:0] AddrMcycleh   = 12'hB80;
  localparam logic [11:0] AddrMvendorid = 12'hF11;
  localparam logic [11:0] AddrMarchid   = 12'hF12;

  localparam logic [CSRCTL_WIDTH-1:0] CtrlNop = CSRCTL_WIDTH'(0);
  localparam logic [CSRCTL_WIDTH-1:0] CtrlWri = CSRCTL_WIDTH'(1);
  localparam logic [CSRCTL_WIDTH-1:0] CtrlSet = CSRCTL_WIDTH'(2);
  localparam logic [CSRCTL_WIDTH-1:0] CtrlClr = CSRCTL_WIDTH'(3);

  // Architectural state
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [63:0]     mcycle_q, mcycle_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic            csr_impl;
  logic [XLEN-1:0] csr_old;
  logic [XLEN-1:0] csr_new;
  logic            ctrl_nop;
  logic            write_req;
  logic            csr_illegal;
  logic            csr_we;
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] mepc_rd;

  assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};
  assign mepc_rd    = {mepc_q[XLEN-1:2], 2'b00};

  // Address decode and raw read of the addressed CSR
  always_comb begin
    csr_impl = 1'b0;
    csr_old  = '0;
    case (I_csr_addr)
      AddrMstatus: begin
        csr_impl       = 1'b1;
        csr_old[12:11] = 2'b11;
        csr_old[7]     = mpie_q;
        csr_old[3]     = mie_q;
      end
      AddrMtvec: begin
        csr_impl = 1'b1;
        csr_old  = mtvec_base;
      end
      AddrMscratch: begin
        csr_impl = 1'b1;
        csr_old  = mscratch_q;
      end
      AddrMepc: begin
        csr_impl = 1'b1;
        csr_old  = mepc_rd;
      end
      AddrMcause: begin
        csr_impl = 1'b1;
        csr_old  = mcause_q;
      end
      AddrMcycle: begin
        csr_impl = 1'b1;
        csr_old  = mcycle_q[XLEN-1:0];
      end
      AddrMcycleh: begin
        // Upper counter half only exists as a separate CSR on RV32
        if (XLEN == 32) begin
          csr_impl = 1'b1;
          csr_old  = XLEN'(mcycle_q[63:32]);
        end
      end
      AddrMvendorid, AddrMarchid: begin
        csr_impl = 1'b1;
      end
      default: begin
        csr_impl = 1'b0;
      end
    endcase
  end

  // New CSR value from the operation; NOP simply passes the old value through
  always_comb begin
    csr_new = csr_old;
    case (I_csr_ctrl)
      CtrlWri: csr_new = I_csr_src;
      CtrlSet: csr_new = csr_old | I_csr_src;
      CtrlClr: csr_new = csr_old & ~I_csr_src;
      default: csr_new = csr_old;
    endcase
  end

  // Write intent, legality and final write enable
  always_comb begin
    ctrl_nop    = (I_csr_ctrl == CtrlNop);
    write_req   = (I_csr_ctrl == CtrlWri) ||
                  (((I_csr_ctrl == CtrlSet) || (I_csr_ctrl == CtrlClr)) && !I_csr_src_x0);
    // Read-only space (addr[11:10] == 2'b11) only faults if something would be written
    csr_illegal = I_csr_valid && !ctrl_nop &&
                  (!csr_impl || ((I_csr_addr[11:10] == 2'b11) && write_req));
    csr_we      = I_csr_valid && !ctrl_nop && !csr_illegal && write_req && !I_trap_valid;
  end

  // Next-state: trap beats MRET beats CSR write; counter increments unless written
  always_comb begin
    mie_d            = mie_q;
    mpie_d           = mpie_q;
    mtvec_d          = mtvec_q;
    mscratch_d       = mscratch_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mcycle_d         = mcycle_q + 64'd1;
    redirect_valid_d = I_trap_valid || I_mret;
    redirect_pc_d    = redirect_pc_q;

    if (I_trap_valid) begin
      mepc_d        = I_trap_pc;
      mcause_d      = I_trap_cause;
      mpie_d        = mie_q;
      mie_d         = 1'b0;
      redirect_pc_d = mtvec_base;
    end else if (I_mret) begin
      mie_d         = mpie_q;
      mpie_d        = 1'b1;
      redirect_pc_d = mepc_rd;
    end

    if (csr_we) begin
      case (I_csr_addr)
        AddrMstatus: begin
          // MRET owns mstatus when both land in the same cycle
          if (!I_mret) begin
            mie_d  = csr_new[3];
            mpie_d = csr_new[7];
          end
        end
        AddrMtvec:    mtvec_d    = csr_new;
        AddrMscratch: mscratch_d = csr_new;
        AddrMepc:     mepc_d     = csr_new;
        AddrMcause:   mcause_d   = csr_new;
        AddrMcycle: begin
          if (XLEN >= 64) begin
            mcycle_d = 64'(csr_new);
          end else begin
            mcycle_d = {mcycle_q[63:32], csr_new[31:0]};
          end
        end
        AddrMcycleh: mcycle_d = {csr_new[31:0], mcycle_q[31:0]};
        default: ;
      endcase
    end
  end

  // State registers; reset also kills any pending redirect at once
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mie_q            <= 1'b0;
      mpie_q           <= 1'b0;
      mtvec_q          <= '0;
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mcycle_q         <= MCYCLE_RST;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      mie_q            <= mie_d;
      mpie_q           <= mpie_d;
      mtvec_q          <= mtvec_d;
      mscratch_q       <= mscratch_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mcycle_q         <= mcycle_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // Outputs
  always_comb begin
    O_csr_rdata      = (I_csr_valid && !csr_illegal) ? csr_old : '0;
    O_csr_illegal    = csr_illegal;
    O_redirect_valid = redirect_valid_q;
    O_redirect_pc    = redirect_pc_q;
    O_mie            = mie_q;
  end

endmodule

// File: doc/exe_csr_unit.md
Name: exe_csr_unit

Overview:
Parametrised successor to the combinational CSR write-data path in the execute stage. Holds the machine-mode CSR file and performs CSRRW/CSRRS/CSRRC (register and immediate forms) read-modify-write in a single cycle. Adds illegal-access detection, trap entry and MRET state updates, a registered PC redirect, and a free-running cycle counter. Sits in EXE beside the ALU; commit logic consumes the redirect and illegal flags.

Parameters:
XLEN, 32, data width of CSRs and operands (32 or 64)
CSRCTL_WIDTH, 2, width of the CSR operation control field
MCYCLE_RST, 0, reset value of the 64-bit cycle counter

Ports:
I_clk  input  1  clock, rising edge
I_rst_n  input  1  asynchronous active-low reset
I_csr_valid  input  1  CSR instruction present in EXE this cycle
I_csr_addr  input  12  CSR address
I_csr_ctrl  input  CSRCTL_WIDTH  00 NOP, 01 WRI, 10 SET, 11 CLR
I_csr_src  input  XLEN  rs1 value or zero-extended zimm
I_csr_src_x0  input  1  rs1 index or zimm is zero (suppresses SET/CLR write)
I_trap_valid  input  1  take exception/interrupt this cycle
I_trap_cause  input  XLEN  value for mcause
I_trap_pc  input  XLEN  faulting PC for mepc
I_mret  input  1  MRET retiring this cycle
O_csr_rdata  output  XLEN  old CSR value (to rd), combinational
O_csr_illegal  output  1  illegal CSR access, combinational
O_redirect_valid  output  1  registered: fetch redirect pending
O_redirect_pc  output  XLEN  registered redirect target
O_mie  output  1  mstatus.MIE for interrupt gating

Behaviour:
- Reset (I_rst_n low, asynchronous): mstatus=0 except MPP=2'b11; mtvec, mepc, mcause, mscratch = 0; mcycle = MCYCLE_RST; O_redirect_valid=0; O_redirect_pc=0.
- Implemented CSRs: mstatus 0x300 (only MIE bit3, MPIE bit7 writable; MPP bits12:11 read 2'b11), mtvec 0x305 (bits1:0 read 0), mscratch 0x340, mepc 0x341 (bits1:0 read 0), mcause 0x342, mcycle 0xB00 (low XLEN bits), mcycleh 0xB80 (bits63:32, XLEN=32 only), mvendorid 0xF11 and marchid 0xF12 (read 0).
- Read: O_csr_rdata = current value of addressed CSR, combinational; 0 when not valid or illegal.
- New value: WRI -> src; SET -> old | src; CLR -> old & ~src; NOP -> no write, never a latched or undefined value.
- Write enable: valid & ctrl!=NOP & ~illegal & ~(ctrl in {SET,CLR} & I_csr_src_x0) & ~I_trap_valid. Takes effect at the next rising edge; read value in the same cycle is the old value.
- Illegal when valid and ctrl!=NOP and: unimplemented address, or mcycleh with XLEN=64, or addr[11:10]==2'b11 and a write would occur. An illegal access writes nothing.
- Priority per cycle: trap > mret > CSR write. mcycle increment sits below a CSR write to mcycle/mcycleh: written half takes written value, other half keeps old value, no increment that cycle.
- Trap: mepc<=trap_pc, mcause<=trap_cause, MPIE<=MIE, MIE<=0; next cycle O_redirect_valid=1, O_redirect_pc={mtvec[XLEN-1:2],2'b00}.
- MRET (no trap): MIE<=MPIE, MPIE<=1; next cycle redirect to old mepc.
- O_redirect_valid is a one-cycle pulse; back-to-back events give back-to-back pulses.
- mcycle increments by 1 every cycle, 64-bit, wraps 0xFFFF_FFFF_FFFF_FFFF -> 0; at XLEN=32 low-half carry propagates to mcycleh in the same cycle.
- Reset asserted mid-operation clears a pending redirect immediately.

Test Plan:
- Reset release, read 0x300 -> rdata 0x1800, redirect_valid 0; read 0xB00 on consecutive cycles -> increments by 1.
- WRI 0x340 src 0xA5A5_0F0F, then SET src 0x0000_F000 -> read 0xA5A5_FF0F; CLR src 0xA5A5_0000 -> 0x0000_FF0F; SET with src_x0=1 -> value unchanged.
- Write mtvec 0x8000_0003 (reads 0x8000_0000), set MIE; trap cause 0x2, pc 0x8000_0104 -> next cycle redirect 0x8000_0000, mepc 0x8000_0104, mcause 2, MIE 0, MPIE 1; MRET -> redirect 0x8000_0104, MIE 1.
- Same-cycle trap, mret and WRI to mscratch -> only trap effects; mscratch unchanged.
- WRI 0xF11 -> illegal 1, no write; read 0xF11 via SET with src_x0=1 -> illegal 0, rdata 0; address 0x7C0 -> illegal 1.
- WRI mcycle 0xFFFF_FFFF with mcycleh 0 (XLEN=32) -> next cycle 0xFFFF_FFFF, following cycle mcycle 0, mcycleh 1; async reset mid-redirect -> redirect_valid drops immediately.
